// File: rtl/aes128_key_sched_ctrl_pkg.sv
// aes128_key_sched_ctrl_pkg: AES S-box, FSM state encoding and the Rcon xtime step
package aes128_key_sched_ctrl_pkg;
   localparam int NR_MAX = 10;
   typedef enum logic [2:0] {IDLE, LOAD, GWAIT, EXPAND, FIN} state_t;
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes128_key_sched_ctrl_g_word.sv
// aes128_key_sched_ctrl_g_word: registered RotWord/SubWord/Rcon stage of the key schedule
module aes128_key_sched_ctrl_g_word
   import aes128_key_sched_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        en,
   input  logic [31:0] word,
   input  logic [7:0]  rcon,
   output logic [31:0] g
);
   logic [31:0] r;
   always_ff @(posedge clk) if (en) r <= word;
   // Rcon is added in GF(2), so it is an XOR onto the rotated first byte
   assign g = {SBOX[r[23:16]] ^ rcon, SBOX[r[15:8]], SBOX[r[7:0]], SBOX[r[31:24]]};
endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// aes128_key_sched_ctrl: sequences AES-128 key expansion and stores all round keys
module aes128_key_sched_ctrl
   import aes128_key_sched_ctrl_pkg::*;
#(
   parameter int NR       = NR_MAX,
   parameter bit STORE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         rk_valid,
   output logic [3:0]   rk_round,
   output logic [127:0] rk_out,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);
   localparam logic [3:0] LAST = 4'(NR);
   state_t state, nxt;
   logic accept, load, step, fin;
   logic [127:0] w, w_nxt;
   logic [3:0] round, rnd_nxt;
   logic [7:0] rcon;
   logic [NR:0] mask;
   logic [31:0] g;
   assign rnd_nxt = round + 4'd1;
   assign w_nxt[127:96] = w[127:96] ^ g;
   assign w_nxt[95:64]  = w[95:64] ^ w_nxt[127:96];
   assign w_nxt[63:32]  = w[63:32] ^ w_nxt[95:64];
   assign w_nxt[31:0]   = w[31:0] ^ w_nxt[63:32];
   aes128_key_sched_ctrl_g_word u_g (
      .clk  (clk),
      .en   (load | step),
      .word (load ? w[31:0] : w_nxt[31:0]),
      .rcon (rcon),
      .g    (g)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      accept = 1'b0;
      load = 1'b0;
      step = 1'b0;
      fin = 1'b0;
      case (state)
         IDLE:    begin accept = start && !busy; nxt = accept ? LOAD : IDLE; end
         LOAD:    begin load = 1'b1; nxt = GWAIT; end
         GWAIT:   nxt = EXPAND;
         EXPAND:  begin step = 1'b1; nxt = (rnd_nxt == LAST) ? FIN : GWAIT; end
         FIN:     begin fin = 1'b1; nxt = IDLE; end
         default: nxt = IDLE;
      endcase
   end
   // busy stays high through the done cycle, so a start seen then is ignored
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         rk_valid <= 1'b0;
         rk_round <= '0;
         rk_out <= '0;
         w <= '0;
         round <= '0;
         rcon <= 8'h01;
         mask <= '0;
      end else begin
         busy <= accept ? 1'b1 : (done ? 1'b0 : busy);
         done <= fin;
         rk_valid <= load | step;
         if (accept) begin
            w <= key_in;
            rcon <= 8'h01;
            round <= '0;
            mask <= '0;
         end
         if (load) begin
            rk_round <= '0;
            rk_out <= w;
            mask[0] <= 1'b1;
         end
         if (step) begin
            w <= w_nxt;
            rk_out <= w_nxt;
            rk_round <= rnd_nxt;
            round <= rnd_nxt;
            rcon <= xtime(rcon);
            mask[rnd_nxt] <= 1'b1;
         end
      end
   if (STORE_EN) begin : g_store
      logic [127:0] keys [NR+1];
      always_ff @(posedge clk)
         if (load) keys[0] <= w;
         else if (step) keys[rnd_nxt] <= w_nxt;
      assign rd_key = (rd_idx <= LAST && mask[rd_idx]) ? keys[rd_idx] : '0;
   end else begin : g_nostore
      assign rd_key = '0;
   end
endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// tb_aes128_key_sched_ctrl: directed FIPS-197 and timing scenarios for the key schedule controller
module tb_aes128_key_sched_ctrl;
   logic clk = 1'b0;
   logic rst_n, start, busy, done, rk_valid;
   logic [127:0] key_in, rk_out, rd_key;
   logic [3:0] rk_round, rd_idx;
   int n_cmp = 0;
   int n_err = 0;
   logic [127:0] got [16];
   logic [31:0] vpat, bpat, dpat;
   int pulses, rerr;
   localparam logic [127:0] FIPS [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes128_key_sched_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
      .busy(busy), .done(done), .rk_valid(rk_valid), .rk_round(rk_round),
      .rk_out(rk_out), .rd_idx(rd_idx), .rd_key(rd_key)
   );
   always #5 clk = ~clk;

   // Runs one expansion for 30 cycles after the accepting edge, recording per-cycle flags
   task automatic run(input logic [127:0] key, input int inj, input logic [127:0] ikey);
      @(negedge clk);
      key_in = key;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      vpat = '0;
      bpat = '0;
      dpat = '0;
      bpat[0] = busy;
      pulses = 0;
      rerr = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (rk_valid) begin
            pulses++;
            vpat[k] = 1'b1;
            if (rk_round !== 4'((k - 1) / 2)) rerr++;
            got[rk_round] = rk_out;
         end
         bpat[k] = busy;
         dpat[k] = done;
         if (k + 1 == inj) begin
            start = 1'b1;
            key_in = ikey;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++;
      if ({busy, done, rk_valid, rk_round} !== 7'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 0", {busy, done, rk_valid, rk_round});
      end
      n_cmp++;
      if (rk_out !== 128'd0 || rd_key !== 128'd0) begin
         n_err++;
         $display("FAIL reset_data: rk_out %h rd_key %h want 0", rk_out, rd_key);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fips;
      run(FIPS[0], 0, '0);
      for (int i = 0; i <= 10; i++) begin
         n_cmp++;
         if (got[i] !== FIPS[i]) begin
            n_err++;
            $display("FAIL fips_rk%0d: got %h want %h", i, got[i], FIPS[i]);
         end
      end
   endtask

   task automatic test_zero_key;
      run('0, 0, '0);
      n_cmp++;
      if (got[1] !== Z1) begin
         n_err++;
         $display("FAIL zero_rk1: got %h want %h", got[1], Z1);
      end
      n_cmp++;
      if (got[10] !== Z10) begin
         n_err++;
         $display("FAIL zero_rk10: got %h want %h", got[10], Z10);
      end
   endtask

   task automatic test_timing;
      run(FIPS[0], 0, '0);
      n_cmp++;
      if (vpat !== 32'h002aaaaa) begin
         n_err++;
         $display("FAIL valid_cycles: got %h want 002aaaaa", vpat);
      end
      n_cmp++;
      if (dpat !== 32'h00400000) begin
         n_err++;
         $display("FAIL done_cycle: got %h want 00400000", dpat);
      end
      n_cmp++;
      if (bpat !== 32'h007fffff) begin
         n_err++;
         $display("FAIL busy_cycles: got %h want 007fffff", bpat);
      end
      n_cmp++;
      if (pulses !== 11 || rerr !== 0) begin
         n_err++;
         $display("FAIL pulse_count: got %0d pulses %0d bad rounds want 11 and 0", pulses, rerr);
      end
   endtask

   task automatic test_start_while_busy;
      run(FIPS[0], 5, Z10);
      n_cmp++;
      if (got[1] !== FIPS[1] || got[10] !== FIPS[10]) begin
         n_err++;
         $display("FAIL busy_start_keys: got %h / %h want %h / %h", got[1], got[10], FIPS[1], FIPS[10]);
      end
      n_cmp++;
      if (vpat !== 32'h002aaaaa || dpat !== 32'h00400000) begin
         n_err++;
         $display("FAIL busy_start_timing: got %h / %h want 002aaaaa / 00400000", vpat, dpat);
      end
   endtask

   task automatic test_read_during;
      @(negedge clk);
      key_in = FIPS[0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rd_idx = 4'd1;
      #1;
      n_cmp++;
      if (rd_key !== 128'd0) begin
         n_err++;
         $display("FAIL rd_cleared: got %h want 0", rd_key);
      end
      @(posedge clk);
      #1;
      rd_idx = 4'd0;
      #1;
      n_cmp++;
      if (rd_key !== FIPS[0]) begin
         n_err++;
         $display("FAIL rd_key0_early: got %h want %h", rd_key, FIPS[0]);
      end
      rd_idx = 4'd1;
      @(posedge clk);
      #2;
      n_cmp++;
      if (rd_key !== 128'd0) begin
         n_err++;
         $display("FAIL rd_key1_premature: got %h want 0", rd_key);
      end
      @(posedge clk);
      #2;
      n_cmp++;
      if (rd_key !== FIPS[1]) begin
         n_err++;
         $display("FAIL rd_key1_written: got %h want %h", rd_key, FIPS[1]);
      end
      for (int k = 0; k < 40 && busy; k++) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rd_run_end: busy %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      @(negedge clk);
      key_in = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (k = 0; k < 40 && !done; k++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_done_seen: done %b want 1", done);
      end
      key_in = FIPS[0];
      start = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || rk_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_fin_ignored: busy %b rk_valid %b want 0 0", busy, rk_valid);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept: busy %b want 1", busy);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_out !== FIPS[0]) begin
         n_err++;
         $display("FAIL b2b_rk0: valid %b round %0d key %h want 1 0 %h", rk_valid, rk_round, rk_out, FIPS[0]);
      end
      for (k = 0; k < 40 && busy; k++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      key_in = FIPS[0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, rk_valid, rk_round} !== 7'd0 || rk_out !== 128'd0) begin
         n_err++;
         $display("FAIL midreset_outputs: ctrl %b key %h want 0", {busy, done, rk_valid, rk_round}, rk_out);
      end
      for (int i = 0; i <= 10; i++) begin
         rd_idx = 4'(i);
         #1;
         n_cmp++;
         if (rd_key !== 128'd0) begin
            n_err++;
            $display("FAIL midreset_rd%0d: got %h want 0", i, rd_key);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_held: done %b busy %b want 0 0", done, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run(FIPS[0], 0, '0);
      n_cmp++;
      if (got[1] !== FIPS[1] || got[10] !== FIPS[10] || dpat !== 32'h00400000) begin
         n_err++;
         $display("FAIL midreset_rerun: got %h / %h done %h want %h / %h 00400000", got[1], got[10], dpat, FIPS[1], FIPS[10]);
      end
   endtask

   task automatic test_sweep;
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         n_cmp++;
         if (rd_key !== (i <= 10 ? FIPS[i % 11] : 128'd0)) begin
            n_err++;
            $display("FAIL sweep_idx%0d: got %h want %h", i, rd_key, (i <= 10 ? FIPS[i % 11] : 128'd0));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      key_in = '0;
      rd_idx = '0;
      test_reset;
      test_fips;
      test_zero_key;
      test_timing;
      test_start_while_busy;
      test_read_during;
      test_back_to_back;
      test_reset_mid;
      test_sweep;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
